// File: rtl/timer_counter.sv
// Prescaled 8-bit up/down timer core with level load and one-cycle
// overflow/underflow trigger pulses for the timer register block.
module timer_counter #(
  parameter int WIDTH = 8
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             en,
  input  logic             load,
  input  logic             updown,
  input  logic [1:0]       cks,
  input  logic [WIDTH-1:0] tdr,
  output logic [WIDTH-1:0] tcnt,
  output logic             ovf_trig,
  output logic             udf_trig
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [3:0] div_cnt;
  logic [3:0] div_mask;
  logic       tick;

  // Low cks+1 bits of the prescaler all ones marks the last cycle of a period.
  always_comb begin
    div_mask = 4'b0001;
    case (cks)
      2'b00:   div_mask = 4'b0001;
      2'b01:   div_mask = 4'b0011;
      2'b10:   div_mask = 4'b0111;
      default: div_mask = 4'b1111;
    endcase
  end

  assign tick = en & ~load & ((div_cnt & div_mask) == div_mask);

  always_ff @(posedge pclk) begin
    if (preset) begin
      tcnt     <= '0;
      div_cnt  <= 4'd0;
      ovf_trig <= 1'b0;
      udf_trig <= 1'b0;
    end else if (load) begin
      tcnt     <= tdr;
      div_cnt  <= 4'd0;
      ovf_trig <= 1'b0;
      udf_trig <= 1'b0;
    end else begin
      ovf_trig <= 1'b0;
      udf_trig <= 1'b0;
      if (en) begin
        div_cnt <= div_cnt + 4'd1;
      end
      if (tick) begin
        if (!updown) begin
          tcnt     <= tcnt + CNT_ONE;
          ovf_trig <= &tcnt;
        end else begin
          tcnt     <= tcnt - CNT_ONE;
          udf_trig <= ~|tcnt;
        end
      end
    end
  end

endmodule
